// File: rtl/fifo_rd_arb_pkg.sv
// Shared definitions for the two-requester FIFO read arbiter.
package fifo_rd_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Number of requesters competing for the FIFO read port
    localparam int NUM_REQ = 2;

    // Default maximum number of words popped per grant
    localparam int BURST_MAX_DEFAULT = 4;

    // One-hot grant vector for a requester index
    function automatic logic [NUM_REQ-1:0] onehot_gnt(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational 2-way round-robin pick: the favoured requester wins when it
// requests, otherwise the other one does.
module rr_pick
    import fifo_rd_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ptr_i,
    output logic               vld_o,
    output logic               idx_o
);

    // Select the favoured requester first, fall back to the other
    always_comb begin
        vld_o = |req_i;
        idx_o = ptr_i;
        if (!req_i[ptr_i]) begin
            idx_o = ~ptr_i;
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side arbiter: grants FIFO read ownership to one of two requesters,
// pops up to BURST_MAX words per grant into a single registered output slot.
module fifo_rd_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = BURST_MAX_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rinc_o,
    input  logic [NUM_REQ-1:0]    req_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t                  state_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic                    gidx_q;
    logic [3:0]              cnt_q;
    logic [3:0]              cnt_d;
    logic                    ptr_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_valid_q;

    logic                    pick_vld;
    logic                    pick_idx;
    logic                    slot_free;
    logic                    req_own;
    logic                    pop;
    logic                    grant_end;

    rr_pick u_rr_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    // Pop qualification and grant-release decision for the current cycle
    always_comb begin
        slot_free = !out_valid_q || out_ready_i;
        req_own   = req_i[gidx_q];
        cnt_d     = cnt_q + 4'd1;
        pop       = (state_q == XFER) && slot_free && !fifo_empty_i &&
                    req_own && (cnt_q < BURST_LIM);
        // Release only once the slot is drained so a popped word is never lost
        grant_end = (state_q == XFER) &&
                    ((cnt_q == BURST_LIM) || fifo_empty_i || !req_own) &&
                    !pop && slot_free;
    end

    // Arbitration FSM: grant, burst count and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_i && pick_vld) begin
                        state_q <= XFER;
                        gnt_q   <= onehot_gnt(pick_idx);
                        gidx_q  <= pick_idx;
                    end
                end
                XFER: begin
                    if (pop) begin
                        cnt_q <= cnt_d;
                    end
                    if (grant_end) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        ptr_q   <= ~gidx_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output slot: load on pop, drain on accept
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_data_q  <= fifo_rdata_i;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign fifo_rinc_o = pop;
    assign gnt_o       = gnt_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (state_q != IDLE);

endmodule
